// File: rtl/darkuart_txsched.sv
// darkuart_txsched
//   Two-channel transmit scheduler in front of the DarkRISCV UART register
//   port. Each producer owns a small circular FIFO; a round-robin FSM hands
//   one byte at a time to the UART byte-1 write lane and waits for the UART
//   TX-busy bit to clear before sending the next. A watchdog raises a sticky
//   error if the UART never finishes a frame.
//
// Ports
//   CLK, RESN              clock (rising edge), async active-low reset
//   C0_VALID/DATA/READY    channel 0 producer handshake
//   C1_VALID/DATA/READY    channel 1 producer handshake
//   UART_WR/BE/DATAI       write strobe, byte enables, write data to UART
//   UART_DATAO             UART read data, bit 0 = TX busy
//   ERR, ERR_CLR           sticky watchdog flag and its clear
//   LEVEL0, LEVEL1         FIFO occupancy per channel
//   BUSY                   FSM not idle or any FIFO non-empty

module darkuart_txsched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                     CLK,
  input  logic                     RESN,
  input  logic                     C0_VALID,
  input  logic [7:0]               C0_DATA,
  output logic                     C0_READY,
  input  logic                     C1_VALID,
  input  logic [7:0]               C1_DATA,
  output logic                     C1_READY,
  output logic                     UART_WR,
  output logic [3:0]               UART_BE,
  output logic [31:0]              UART_DATAI,
  input  logic [31:0]              UART_DATAO,
  output logic                     ERR,
  input  logic                     ERR_CLR,
  output logic [$clog2(DEPTH):0]   LEVEL0,
  output logic [$clog2(DEPTH):0]   LEVEL1,
  output logic                     BUSY
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  // Per-channel FIFO storage and bookkeeping, indexed by channel number
  logic [7:0]    mem_q   [2][DEPTH];
  logic [AW-1:0] wptr_q  [2];
  logic [AW-1:0] rptr_q  [2];
  logic [LW-1:0] level_q [2];
  logic [7:0]    data_in [2];

  logic [1:0]  ready;
  logic [1:0]  push;
  logic [1:0]  pop;
  logic [1:0]  not_empty;

  logic [1:0]  state_q, state_d;
  logic        sel_q, sel_d;
  logic        last_q, last_d;
  logic [15:0] timer_q, timer_d;
  logic        err_q, err_d;
  logic        err_set;
  logic        uart_busy;
  logic [7:0]  head;

  // Only the TX-busy bit of the UART status word matters here
  logic        unused_datao;
  assign unused_datao = ^UART_DATAO[31:1];
  assign uart_busy    = UART_DATAO[0];

  assign data_in[0] = C0_DATA;
  assign data_in[1] = C1_DATA;

  // Ready comes only from the registered level, so a full FIFO refuses a
  // push even in the cycle its head is being popped
  assign ready[0]     = level_q[0] < LW'(DEPTH);
  assign ready[1]     = level_q[1] < LW'(DEPTH);
  assign push[0]      = C0_VALID & ready[0];
  assign push[1]      = C1_VALID & ready[1];
  assign pop[0]       = (state_q == S_ISSUE) & ~sel_q;
  assign pop[1]       = (state_q == S_ISSUE) &  sel_q;
  assign not_empty[0] = level_q[0] != '0;
  assign not_empty[1] = level_q[1] != '0;

  assign head = mem_q[sel_q][rptr_q[sel_q]];

  // FIFO pointers and levels; DEPTH is a power of two so pointers wrap
  // naturally on overflow
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      for (int c = 0; c < 2; c++) begin
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
        level_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) wptr_q[c] <= wptr_q[c] + 1'b1;
        if (pop[c])  rptr_q[c] <= rptr_q[c] + 1'b1;
        case ({push[c], pop[c]})
          2'b10:   level_q[c] <= level_q[c] + 1'b1;
          2'b01:   level_q[c] <= level_q[c] - 1'b1;
          default: level_q[c] <= level_q[c];
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only read once the level says valid
  always_ff @(posedge CLK) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem_q[c][wptr_q[c]] <= data_in[c];
    end
  end

  // Scheduler FSM: pick a channel, strobe one write, skip the cycle before
  // the UART busy bit becomes visible, then wait for it to clear or time out
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    timer_d = timer_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!uart_busy && (not_empty != 2'b00)) begin
          if (not_empty == 2'b11) sel_d = ~last_q;
          else                    sel_d = not_empty[1];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        last_d  = sel_q;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!uart_busy) begin
          state_d = S_IDLE;
        end else if (timer_q == 16'(TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A timeout in the same cycle as a clear request keeps the flag set
  assign err_d = err_set ? 1'b1 : (ERR_CLR ? 1'b0 : err_q);

  // LAST resets to channel 1 so channel 0 wins the first tie
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  // UART write port is decoded purely from registered state
  always_comb begin
    UART_WR    = 1'b0;
    UART_BE    = 4'b0000;
    UART_DATAI = 32'h0;
    if (state_q == S_ISSUE) begin
      UART_WR    = 1'b1;
      UART_BE    = 4'b0010;
      UART_DATAI = {16'h0, head, 8'h0};
    end
  end

  assign C0_READY = ready[0];
  assign C1_READY = ready[1];
  assign LEVEL0   = level_q[0];
  assign LEVEL1   = level_q[1];
  assign ERR      = err_q;
  assign BUSY     = (state_q != S_IDLE) | (not_empty != 2'b00);

endmodule
